// File: rtl/jtframe_uart_fifo_pkg.sv
// Shared constants for the UART FIFO bridge: CPU register map, STATUS/CTRL
// bit positions and the Tx engine state encoding.
package jtframe_uart_fifo_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_RXDATA = 2'd2;
    localparam logic [1:0] ADDR_TXDATA = 2'd3;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_OVF    = 2;
    localparam int ST_RX_ERR    = 3;
    localparam int ST_TX_IDLE   = 4;
    localparam int ST_TX_OVF    = 5;

    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TXE_IE = 1;
    localparam int CTRL_CLR    = 7;

    localparam int TX_TIMEOUT = 16;
    localparam int TMR_W      = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/jtframe_uart_fifo_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; a pop on a non-empty
// FIFO frees its slot so a simultaneous push is accepted even when full.
module jtframe_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [DW-1:0] mem_q [2**AW];
    logic          do_push, do_pop;

    always_comb begin
        empty   = (wp_q == rp_q);
        full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wp_d    = wp_q + {{AW{1'b0}}, do_push};
        rp_d    = rp_q + {{AW{1'b0}}, do_pop};
        head    = mem_q[rp_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtframe_uart_fifo.sv
// CPU-side register bridge between a byte UART core and the CPU bus, with
// Rx/Tx FIFOs, sticky error flags, a Tx feeder engine and an interrupt.
module jtframe_uart_fifo
    import jtframe_uart_fifo_pkg::*;
#(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          cs,
    input  logic [1:0]    A,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          irq_n,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_done,
    input  logic          rx_error,
    output logic [DW-1:0] tx_data,
    output logic          tx_wr,
    input  logic          tx_busy
);

    logic          wr_acc, rd_acc, wr_acc_q, wr_acc_d, rd_acc_q, rd_acc_d;
    logic          wr_fire, ctrl_wr, rx_push, rx_pop, tx_push, tx_pop;
    logic          rx_full, rx_empty, tx_full, tx_empty, tx_idle;
    logic [DW-1:0] rx_head, tx_head, status, ctrl_rd;
    logic          rx_ie_q, rx_ie_d, txe_ie_q, txe_ie_d;
    logic          rx_ovf_q, rx_ovf_d, rx_err_q, rx_err_d, tx_ovf_q, tx_ovf_d;
    logic          irq_n_q, irq_n_d, tx_wr_q, tx_wr_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    tx_state_e     state_q, state_d;

    // Writes act on the leading cen of an access; the RXDATA pop waits for
    // the trailing cen so the CPU sees a stable head for the whole read.
    always_comb begin
        wr_acc   = cs & ~wr_n;
        rd_acc   = cs & ~rd_n & (A == ADDR_RXDATA);
        wr_fire  = cen & wr_acc & ~wr_acc_q;
        rx_pop   = cen & rd_acc_q & ~rd_acc;
        rx_push  = cen & rx_done;
        tx_push  = wr_fire & (A == ADDR_TXDATA);
        ctrl_wr  = wr_fire & (A == ADDR_CTRL);
        tx_pop   = cen & (state_q == TX_LOAD);
        wr_acc_d = cen ? wr_acc : wr_acc_q;
        rd_acc_d = cen ? rd_acc : rd_acc_q;
        tx_idle  = (state_q == TX_IDLE) & tx_empty & ~tx_busy;
    end

    always_comb begin
        rx_ie_d  = rx_ie_q;
        txe_ie_d = txe_ie_q;
        rx_ovf_d = rx_ovf_q;
        rx_err_d = rx_err_q;
        tx_ovf_d = tx_ovf_q;
        if (ctrl_wr) begin
            rx_ie_d  = din[CTRL_RX_IE];
            txe_ie_d = din[CTRL_TXE_IE];
            if (din[CTRL_CLR]) begin
                rx_ovf_d = 1'b0;
                rx_err_d = 1'b0;
                tx_ovf_d = 1'b0;
            end
        end
        // A new event on the clearing cen still gets recorded.
        if (rx_push & rx_full & ~rx_pop) rx_ovf_d = 1'b1;
        if (cen & rx_error)              rx_err_d = 1'b1;
        if (tx_push & tx_full & ~tx_pop) tx_ovf_d = 1'b1;
        irq_n_d = cen ? ~((rx_ie_q & ~rx_empty) | (txe_ie_q & tx_idle) | rx_ovf_q | rx_err_q)
                      : irq_n_q;
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        tx_data_d = tx_data_q;
        if (cen) begin
            case (state_q)
                TX_IDLE: if (!tx_empty && !tx_busy) begin
                    state_d   = TX_LOAD;
                    tx_data_d = tx_head;
                end
                TX_LOAD: begin
                    state_d = TX_WAIT;
                    tmr_d   = '0;
                end
                TX_WAIT: begin
                    if (tx_busy || tmr_q == TMR_W'(TX_TIMEOUT - 1)) state_d = TX_IDLE;
                    else                                             tmr_d   = tmr_q + TMR_W'(1);
                end
                default: state_d = TX_IDLE;
            endcase
        end
        tx_wr_d = (state_d == TX_LOAD);
    end

    always_comb begin
        status                = '0;
        status[ST_RX_NEMPTY]  = ~rx_empty;
        status[ST_TX_FULL]    = tx_full;
        status[ST_RX_OVF]     = rx_ovf_q;
        status[ST_RX_ERR]     = rx_err_q;
        status[ST_TX_IDLE]    = tx_idle;
        status[ST_TX_OVF]     = tx_ovf_q;
        ctrl_rd               = '0;
        ctrl_rd[CTRL_RX_IE]   = rx_ie_q;
        ctrl_rd[CTRL_TXE_IE]  = txe_ie_q;
        dout                  = '0;
        case (A)
            ADDR_STATUS: dout = status;
            ADDR_CTRL:   dout = ctrl_rd;
            ADDR_RXDATA: dout = rx_empty ? '0 : rx_head;
            default:     dout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_acc_q  <= 1'b0;
            rd_acc_q  <= 1'b0;
            rx_ie_q   <= 1'b0;
            txe_ie_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            rx_err_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            irq_n_q   <= 1'b1;
            state_q   <= TX_IDLE;
            tmr_q     <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            wr_acc_q  <= wr_acc_d;
            rd_acc_q  <= rd_acc_d;
            rx_ie_q   <= rx_ie_d;
            txe_ie_q  <= txe_ie_d;
            rx_ovf_q  <= rx_ovf_d;
            rx_err_q  <= rx_err_d;
            tx_ovf_q  <= tx_ovf_d;
            irq_n_q   <= irq_n_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign irq_n   = irq_n_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;

    jtframe_fifo #(.DW(DW), .AW(RX_AW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head)
    );

    jtframe_fifo #(.DW(DW), .AW(TX_AW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (din),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_head)
    );

endmodule

// File: tb/tb_jtframe_uart_fifo.sv
// Bench for jtframe_uart_fifo: queue-based behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_jtframe_uart_fifo;

    localparam int RXD = 16;
    localparam int TXD = 16;

    logic       clk = 0, rst_n = 0, cen = 0, cs = 0, rd_n = 1, wr_n = 1;
    logic       rx_done = 0, rx_error = 0, tx_busy = 0;
    logic [1:0] A = 0;
    logic [7:0] din = 0, rx_data = 0;
    logic [7:0] dout, tx_data;
    logic       irq_n, tx_wr;

    jtframe_uart_fifo #(.RX_AW(4), .TX_AW(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs(cs), .A(A), .rd_n(rd_n),
        .wr_n(wr_n), .din(din), .dout(dout), .irq_n(irq_n),
        .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    // cen is high on every other clock edge.
    initial forever begin @(posedge clk); #1; cen = ~cen; end

    int tests = 0, fails = 0;
    bit chk_en = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_rxq[$], m_txq[$];
    bit m_rx_ie, m_txe_ie, m_rx_ovf, m_rx_err, m_tx_ovf, m_irq_n = 1;
    bit m_wr_prev, m_rd_prev, m_tx_wr;
    logic [7:0] m_tx_data = 0;
    int m_eng = 0, m_waited = 0;   // 0 free, 1 strobing, 2 awaiting busy

    initial begin : model
        bit idle_now, wr_now, rd_now, wfire, pop_rx, pop_tx, irq_next;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_rxq.delete(); m_txq.delete();
                m_rx_ie = 0; m_txe_ie = 0; m_rx_ovf = 0; m_rx_err = 0; m_tx_ovf = 0;
                m_irq_n = 1; m_wr_prev = 0; m_rd_prev = 0; m_tx_wr = 0;
                m_tx_data = 0; m_eng = 0; m_waited = 0;
            end else if (cen) begin
                idle_now = (m_eng == 0) && m_txq.size() == 0 && !tx_busy;
                irq_next = !((m_rx_ie && m_rxq.size() != 0) || (m_txe_ie && idle_now)
                             || m_rx_ovf || m_rx_err);
                wr_now = cs && !wr_n;
                wfire = wr_now && !m_wr_prev;
                m_wr_prev = wr_now;
                rd_now = cs && !rd_n && A == 2'd2;
                pop_rx = m_rd_prev && !rd_now;
                m_rd_prev = rd_now;
                if (wfire && A == 2'd1) begin
                    m_rx_ie = din[0]; m_txe_ie = din[1];
                    if (din[7]) begin m_rx_ovf = 0; m_rx_err = 0; m_tx_ovf = 0; end
                end
                if (pop_rx && m_rxq.size() != 0) void'(m_rxq.pop_front());
                if (rx_done) begin
                    if (m_rxq.size() < RXD) m_rxq.push_back(rx_data);
                    else m_rx_ovf = 1;
                end
                if (rx_error) m_rx_err = 1;
                pop_tx = 0;
                if (m_eng == 0) begin
                    if (m_txq.size() != 0 && !tx_busy) begin m_eng = 1; m_tx_data = m_txq[0]; end
                end else if (m_eng == 1) begin
                    m_eng = 2; m_waited = 0; pop_tx = 1;
                end else begin
                    if (tx_busy || m_waited == 15) m_eng = 0;
                    else m_waited++;
                end
                if (pop_tx) void'(m_txq.pop_front());
                if (wfire && A == 2'd3) begin
                    if (m_txq.size() < TXD) m_txq.push_back(din);
                    else m_tx_ovf = 1;
                end
                m_tx_wr = (m_eng == 1);
                m_irq_n = irq_next;
            end
        end
    end

    function automatic logic [7:0] m_dout();
        logic [7:0] s;
        bit idle;
        idle = (m_eng == 0) && m_txq.size() == 0 && !tx_busy;
        case (A)
            2'd0: s = {2'b00, m_tx_ovf, idle, m_rx_err, m_rx_ovf,
                       (m_txq.size() == TXD), (m_rxq.size() != 0)};
            2'd1: s = {6'b0, m_txe_ie, m_rx_ie};
            2'd2: s = (m_rxq.size() != 0) ? m_rxq[0] : 8'h00;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("dout", dout, m_dout());
            check("irq_n", irq_n, m_irq_n);
            check("tx_wr", tx_wr, m_tx_wr);
            check("tx_data", tx_data, m_tx_data);
        end
    end

    // ---------------- strobe monitor and UART core model ----------------
    int strobes = 0;
    logic [7:0] strobe_data[$];
    bit gap_ok[$];
    bit prev_wr = 0, prev_busy = 0, rose = 0, fell = 0;
    initial forever begin
        @(negedge clk);
        if (tx_busy && !prev_busy) rose = 1;
        if (!tx_busy && prev_busy) fell = 1;
        prev_busy = tx_busy;
        if (tx_wr && !prev_wr) begin
            strobes++;
            strobe_data.push_back(tx_data);
            gap_ok.push_back(rose && fell);
            rose = 0; fell = 0;
            $display("[TB] tx strobe %0d data=%02h", strobes, tx_data);
        end
        prev_wr = tx_wr;
    end

    bit core_on = 0;
    int busy_cnt = -1;
    initial begin : core
        bit tk, w;
        forever begin
            @(negedge clk); tk = cen; w = tx_wr;
            @(posedge clk); #2;
            if (core_on && tk) begin
                if (busy_cnt < 0) begin
                    if (w) busy_cnt = 0;
                end else begin
                    busy_cnt++;
                    if (busy_cnt >= 12) busy_cnt = -1;
                end
                tx_busy = (busy_cnt >= 2);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(); @(posedge clk); #2; endtask
    task automatic cen_step();
        bit c;
        do begin @(posedge clk); c = cen; #2; end while (!c);
    endtask
    task automatic cens(int n); repeat (n) cen_step(); endtask

    task automatic bus_write(logic [1:0] a, logic [7:0] d);
        A = a; din = d; cs = 1; wr_n = 0;
        cen_step();
        cs = 0; wr_n = 1;
        cen_step();
        $display("[TB] wr A=%0d d=%02h", a, d);
    endtask

    task automatic bus_read(logic [1:0] a, int hold, output logic [7:0] d);
        A = a; cs = 1; rd_n = 0;
        #1 d = dout;
        cens(hold);
        cs = 0; rd_n = 1;
        cen_step();
        $display("[TB] rd A=%0d -> %02h", a, d);
    endtask

    task automatic push_rx(logic [7:0] d);
        rx_data = d; rx_done = 1;
        cen_step();
        rx_done = 0;
        $display("[TB] rx_done d=%02h", d);
    endtask

    // ---------------- directed scenarios ----------------
    logic [7:0] r;
    int s0;
    initial begin
        rst_n = 0;
        repeat (4) step();
        chk_en = 1;
        rst_n = 1;
        cens(1);

        // Reset state
        bus_read(2'd0, 1, r);
        check("reset_status", r, 8'h10);
        check("reset_irq_n", irq_n, 1'b1);

        // Rx ordering, held read pops once
        push_rx(8'h41); push_rx(8'h42); push_rx(8'h43);
        bus_read(2'd2, 5, r); check("rx_first", r, 8'h41);
        bus_read(2'd2, 1, r); check("rx_second", r, 8'h42);
        bus_read(2'd2, 1, r); check("rx_third", r, 8'h43);
        bus_read(2'd0, 1, r); check("rx_drained_bit0", r[0], 1'b0);

        // Rx overflow with core busy (so tx_idle is 0)
        tx_busy = 1;
        for (int i = 0; i < 17; i++) push_rx(8'h60 + 8'(i));
        bus_read(2'd0, 1, r); check("rx_ovf_status", r, 8'h05);
        check("rx_ovf_irq_n", irq_n, 1'b0);
        bus_write(2'd1, 8'h80);
        bus_read(2'd0, 1, r); check("ovf_cleared_status", r, 8'h01);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd2, 1, r);
            check("rx_kept", r, 8'h60 + 8'(i));
        end
        tx_busy = 0;
        cens(2);

        // Push coinciding with pop of the last byte
        bus_write(2'd1, 8'h01);
        push_rx(8'h77);
        A = 2'd2; cs = 1; rd_n = 0;
        #1 check("coinc_head", dout, 8'h77);
        cens(2);
        cs = 0; rd_n = 1; rx_data = 8'h88; rx_done = 1;
        cen_step();
        rx_done = 0;
        cen_step();
        check("coinc_irq_n", irq_n, 1'b0);
        bus_read(2'd0, 1, r); check("coinc_status", r, 8'h11);
        bus_read(2'd2, 1, r); check("coinc_data", r, 8'h88);
        cens(2);
        check("coinc_irq_release", irq_n, 1'b1);
        bus_write(2'd1, 8'h00);

        // Two-byte transmit with core handshake
        core_on = 1;
        s0 = strobes;
        bus_write(2'd3, 8'h55);
        bus_write(2'd3, 8'hAA);
        for (int i = 0; i < 200 && strobes < s0 + 2; i++) cen_step();
        check("tx_two_strobes", strobes - s0, 2);
        if (strobes >= s0 + 2) begin
            check("tx_byte0", strobe_data[s0], 8'h55);
            check("tx_byte1", strobe_data[s0 + 1], 8'hAA);
            check("tx_second_after_busy", gap_ok[s0 + 1], 1'b1);
        end
        cens(24);
        core_on = 0;
        check("tx_no_extra", strobes - s0, 2);

        // Tx overflow, rx error, then drain via timeouts
        tx_busy = 1;
        for (int i = 0; i < 17; i++) bus_write(2'd3, 8'h90 + 8'(i));
        bus_read(2'd0, 1, r); check("tx_ovf_status", r, 8'h22);
        check("tx_ovf_irq_n", irq_n, 1'b1);
        rx_error = 1; cen_step(); rx_error = 0;
        cens(1);
        bus_read(2'd0, 1, r); check("rx_err_status", r, 8'h2A);
        check("rx_err_irq_n", irq_n, 1'b0);
        bus_write(2'd1, 8'h80);
        bus_read(2'd0, 1, r); check("flags_cleared", r, 8'h02);
        s0 = strobes;
        tx_busy = 0;
        for (int i = 0; i < 600 && strobes < s0 + 16; i++) cen_step();
        cens(20);
        check("drain_count", strobes - s0, 16);
        if (strobes >= s0 + 16) begin
            check("drain_first", strobe_data[s0], 8'h90);
            check("drain_last", strobe_data[s0 + 15], 8'h9F);
        end
        bus_read(2'd0, 1, r); check("drained_status", r, 8'h10);

        // Reset during WAIT with bytes still queued, on a non-cen edge
        tx_busy = 1;
        for (int i = 0; i < 4; i++) bus_write(2'd3, 8'hC0 + 8'(i));
        s0 = strobes;
        tx_busy = 0;
        for (int i = 0; i < 30 && strobes == s0; i++) cen_step();
        check("pre_reset_strobe", strobes - s0, 1);
        cens(3);
        A = 2'd0;
        while (cen) step();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        check("midrst_status", dout, 8'h10);
        check("midrst_tx_wr", tx_wr, 1'b0);
        check("midrst_irq_n", irq_n, 1'b1);
        cens(60);
        check("midrst_no_strobes", strobes - s0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
